// File: rtl/integral_image_calc.sv
// integral_image_calc: streaming integral-image generator, raster-order pixels in, ii(x,y) plus coordinates out.
// Latency: fixed 2 cycles from an accepted pixel to ii_valid_o (two register stages).
// Backpressure: none; sustains one pixel per cycle, and idle cycles (pix_valid_i=0) freeze all state.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-low reset
//   pix_i        unsigned pixel value, qualified by pix_valid_i
//   pix_valid_i  pixel qualifier
//   sof_i        start of frame, only meaningful with pix_valid_i
//   ii_o         integral value of the pixel at (ii_x_o, ii_y_o), modulo 2^SUM_WIDTH
//   ii_valid_o   ii_o / ii_x_o / ii_y_o / ii_eof_o / frame_err_o qualifier
//   ii_x_o       column of ii_o
//   ii_y_o       row of ii_o
//   ii_eof_o     marks the last pixel of the frame
//   frame_err_o  one-cycle pulse with the output of a pixel that restarted a frame mid-way
module integral_image_calc #(
    parameter int PIX_WIDTH  = 8,
    parameter int IMG_WIDTH  = 320,
    parameter int IMG_HEIGHT = 240,
    parameter int SUM_WIDTH  = 25
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [PIX_WIDTH-1:0]          pix_i,
    input  logic                          pix_valid_i,
    input  logic                          sof_i,
    output logic [SUM_WIDTH-1:0]          ii_o,
    output logic                          ii_valid_o,
    output logic [$clog2(IMG_WIDTH)-1:0]  ii_x_o,
    output logic [$clog2(IMG_HEIGHT)-1:0] ii_y_o,
    output logic                          ii_eof_o,
    output logic                          frame_err_o
);

    localparam int XW = $clog2(IMG_WIDTH);
    localparam int YW = $clog2(IMG_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state, state_nxt;

    // Frame position of the next pixel and the running sum of the current row.
    logic [XW-1:0]        x_cnt, x_nxt, cur_x;
    logic [YW-1:0]        y_cnt, y_nxt, cur_y;
    logic [SUM_WIDTH-1:0] row_sum, row_sum_nxt;

    logic accept;      // pixel enters the pipeline this cycle
    logic restart;     // pixel carries sof and is forced to (0,0)
    logic err;         // sof arrived while a frame was in progress
    logic last;        // pixel is (IMG_WIDTH-1, IMG_HEIGHT-1)

    // Stage 1 registers.
    logic                 s1_vld;
    logic [XW-1:0]        s1_x;
    logic [YW-1:0]        s1_y;
    logic                 s1_eof;
    logic                 s1_err;

    // Line buffer: holds ii of the previous row, one entry per column.
    logic [SUM_WIDTH-1:0] line_buf [IMG_WIDTH];
    logic [SUM_WIDTH-1:0] rd_dat;
    logic [SUM_WIDTH-1:0] ii_sum;

    // ------------------------------------------------------------------
    // Input stage: acceptance, position, row sum and FSM next state.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        restart     = 1'b0;
        err         = 1'b0;
        last        = 1'b0;
        cur_x       = x_cnt;
        cur_y       = y_cnt;
        x_nxt       = x_cnt;
        y_nxt       = y_cnt;
        row_sum_nxt = row_sum;

        case (state)
            IDLE: begin
                // Pixels without sof are dropped until a frame starts.
                if (pix_valid_i && sof_i) begin
                    accept  = 1'b1;
                    restart = 1'b1;
                end
            end
            ACTIVE: begin
                if (pix_valid_i) begin
                    accept  = 1'b1;
                    restart = sof_i;
                    err     = sof_i && ((x_cnt != '0) || (y_cnt != '0));
                end
            end
            default: ;
        endcase

        if (restart) begin
            cur_x = '0;
            cur_y = '0;
        end

        if (accept) begin
            row_sum_nxt = ((cur_x == '0) ? '0 : row_sum) + SUM_WIDTH'(pix_i);
            last        = (cur_x == X_LAST) && (cur_y == Y_LAST);
            if (last) begin
                x_nxt     = '0;
                y_nxt     = '0;
                state_nxt = IDLE;
            end else begin
                state_nxt = ACTIVE;
                if (cur_x == X_LAST) begin
                    x_nxt = '0;
                    y_nxt = cur_y + YW'(1);
                end else begin
                    x_nxt = cur_x + XW'(1);
                    y_nxt = cur_y;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            x_cnt   <= '0;
            y_cnt   <= '0;
            row_sum <= '0;
        end else begin
            state   <= state_nxt;
            x_cnt   <= x_nxt;
            y_cnt   <= y_nxt;
            row_sum <= row_sum_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: register position and flags, issue the line-buffer read.
    // row_sum only moves on accepted pixels, so while s1_vld is high it
    // still holds exactly the row sum of the stage-1 pixel; no copy needed.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_vld <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
            s1_eof <= 1'b0;
            s1_err <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_x   <= cur_x;
                s1_y   <= cur_y;
                s1_eof <= last;
                s1_err <= err;
            end
        end
    end

    // Row 0 masks the read data, so stale RAM contents never matter.
    assign ii_sum = row_sum + ((s1_y == '0) ? '0 : rd_dat);

    // Line buffer RAM: read for the incoming pixel, write for the stage-1
    // pixel. With at least 4 columns the same-edge addresses never collide
    // in a way that matters: a column is re-read a full row after its write.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            rd_dat <= line_buf[cur_x];
        end
        if (s1_vld) begin
            line_buf[s1_x] <= ii_sum;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output registers. Data/coordinates hold when not valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ii_valid_o  <= 1'b0;
            ii_eof_o    <= 1'b0;
            frame_err_o <= 1'b0;
            ii_o        <= '0;
            ii_x_o      <= '0;
            ii_y_o      <= '0;
        end else begin
            ii_valid_o  <= s1_vld;
            ii_eof_o    <= s1_vld && s1_eof;
            frame_err_o <= s1_vld && s1_err;
            if (s1_vld) begin
                ii_o   <= ii_sum;
                ii_x_o <= s1_x;
                ii_y_o <= s1_y;
            end
        end
    end

endmodule

// File: tb/tb_integral_image_calc.sv
// tb_integral_image_calc: self-checking bench for integral_image_calc (4x3 frames).
// Latency: expects every accepted pixel at the output exactly 2 cycles after it is driven.
// Backpressure: none; stimulus streams with optional random idle gaps.
module tb_integral_image_calc;

    localparam int W = 4;
    localparam int H = 3;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] pix   = '0;
    logic       vld   = 1'b0;
    logic       sof   = 1'b0;

    logic [24:0] ii;
    logic        ii_vld;
    logic [1:0]  ii_x;
    logic [1:0]  ii_y;
    logic        ii_eof;
    logic        ferr;

    logic [7:0]  ii8;
    logic        ii_vld8;
    logic [1:0]  ii_x8;
    logic [1:0]  ii_y8;
    logic        ii_eof8;
    logic        ferr8;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int ii;
        int x;
        int y;
        bit eof;
        bit err;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Reference model state.
    bit m_active;
    int m_x, m_y, m_rs;
    int m_lb[W];

    // Monitor statistics.
    int out_cnt = 0, eof_cnt = 0, err_cnt = 0;
    int last_ii = 0, last_ii8 = 0, eof_ii = 0, err_ii = 0, err_x = 0, err_y = 0;
    int cap[H][W];
    int save[H][W];

    integral_image_calc #(.PIX_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SUM_WIDTH(25)) dut (
        .clk_i(clk), .rst_i(rst_n), .pix_i(pix), .pix_valid_i(vld), .sof_i(sof),
        .ii_o(ii), .ii_valid_o(ii_vld), .ii_x_o(ii_x), .ii_y_o(ii_y),
        .ii_eof_o(ii_eof), .frame_err_o(ferr)
    );

    integral_image_calc #(.PIX_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .SUM_WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst_n), .pix_i(pix), .pix_valid_i(vld), .sof_i(sof),
        .ii_o(ii8), .ii_valid_o(ii_vld8), .ii_x_o(ii_x8), .ii_y_o(ii_y8),
        .ii_eof_o(ii_eof8), .frame_err_o(ferr8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    task automatic model_reset();
        m_active = 1'b0;
        m_x      = 0;
        m_y      = 0;
        m_rs     = 0;
        q.delete();
    endtask

    task automatic model_pixel(input int p, input bit s);
        exp_t e;
        int   rs;
        int   v;
        if (!m_active && !s) return;
        e.err = m_active && s && (m_x != 0 || m_y != 0);
        if (s) begin
            m_x = 0;
            m_y = 0;
        end
        m_active = 1'b1;
        rs   = ((m_x == 0) ? 0 : m_rs) + p;
        m_rs = rs;
        v    = rs + ((m_y == 0) ? 0 : m_lb[m_x]);
        m_lb[m_x] = v;
        e.ii  = v;
        e.x   = m_x;
        e.y   = m_y;
        e.eof = (m_x == W - 1) && (m_y == H - 1);
        e.cyc = cyc + 2;
        q.push_back(e);
        if (e.eof) begin
            m_active = 1'b0;
            m_x = 0;
            m_y = 0;
        end else if (m_x == W - 1) begin
            m_x = 0;
            m_y = m_y + 1;
        end else begin
            m_x = m_x + 1;
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (ii_vld) begin
            out_cnt++;
            last_ii  = int'(ii);
            last_ii8 = int'(ii8);
            if (ii_y < 2'd3) cap[ii_y][ii_x] = int'(ii);
            if (ii_eof) begin
                eof_cnt++;
                eof_ii = int'(ii);
            end
            if (ferr) begin
                err_cnt++;
                err_ii = int'(ii);
                err_x  = int'(ii_x);
                err_y  = int'(ii_y);
            end
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: ii_valid_o=1 ii=%0d at (%0d,%0d), required no output",
                         ii, ii_x, ii_y);
            end else begin
                mon_e = q.pop_front();
                if (ii !== mon_e.ii[24:0] || ii_x !== mon_e.x[1:0] || ii_y !== mon_e.y[1:0] ||
                    ii_eof !== mon_e.eof || ferr !== mon_e.err || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL sb_main: got ii=%0d x=%0d y=%0d eof=%0d err=%0d cyc=%0d, required ii=%0d x=%0d y=%0d eof=%0d err=%0d cyc=%0d",
                             ii, ii_x, ii_y, ii_eof, ferr, cyc,
                             mon_e.ii[24:0], mon_e.x, mon_e.y, mon_e.eof, mon_e.err, mon_e.cyc);
                end
                checks++;
                if (ii_vld8 !== 1'b1 || ii8 !== mon_e.ii[7:0] || ii_x8 !== mon_e.x[1:0] ||
                    ii_y8 !== mon_e.y[1:0] || ii_eof8 !== mon_e.eof || ferr8 !== mon_e.err) begin
                    errors++;
                    $display("FAIL sb_sum8: got vld=%0d ii=%0d x=%0d y=%0d eof=%0d err=%0d, required vld=1 ii=%0d x=%0d y=%0d eof=%0d err=%0d",
                             ii_vld8, ii8, ii_x8, ii_y8, ii_eof8, ferr8,
                             mon_e.ii[7:0], mon_e.x, mon_e.y, mon_e.eof, mon_e.err);
                end
            end
        end else begin
            checks++;
            if (ii_eof !== 1'b0 || ferr !== 1'b0 || ii_vld8 !== 1'b0 || ii_eof8 !== 1'b0 || ferr8 !== 1'b0) begin
                errors++;
                $display("FAIL idle_flags: eof=%0d err=%0d vld8=%0d eof8=%0d err8=%0d, required all 0",
                         ii_eof, ferr, ii_vld8, ii_eof8, ferr8);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int p, input bit s);
        @(posedge clk);
        #1;
        pix = 8'(p);
        vld = 1'b1;
        sof = s;
        model_pixel(p, s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            vld = 1'b0;
            sof = 1'b0;
        end
    endtask

    // kind 0: all ones, 1: ramp 4y+x, 2: all 255
    task automatic send_frame(input int kind, input bit gaps);
        int p;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                p = (kind == 0) ? 1 : (kind == 1) ? (4 * y + x) : 255;
                drive(p, (x == 0) && (y == 0));
                if (gaps) idle($urandom_range(0, 3));
            end
        end
    endtask

    // Waits (bounded) until every expected output has been seen.
    task automatic drain(output bit ok);
        idle(1);
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        idle(1);
        ok = (q.size() == 0);
    endtask

    task automatic clear_cap();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                cap[y][x] = -1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        vld   = 1'b0;
        sof   = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ii, ii_vld, ii_x, ii_y, ii_eof, ferr} !== '0) begin
            errors++;
            $display("FAIL reset_main: ii=%0d vld=%0d x=%0d y=%0d eof=%0d err=%0d, required all 0",
                     ii, ii_vld, ii_x, ii_y, ii_eof, ferr);
        end
        checks++;
        if ({ii8, ii_vld8, ii_x8, ii_y8, ii_eof8, ferr8} !== '0) begin
            errors++;
            $display("FAIL reset_sum8: ii=%0d vld=%0d x=%0d y=%0d, required all 0", ii8, ii_vld8, ii_x8, ii_y8);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_all_ones();
        int e0;
        bit ok;
        e0 = eof_cnt;
        clear_cap();
        send_frame(0, 1'b0);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ones_drain: %0d outputs missing, required 0", q.size()); end
        for (int x = 0; x < W; x++) begin
            checks++;
            if (cap[2][x] != 3 * (x + 1)) begin
                errors++;
                $display("FAIL ones_row2: x=%0d got %0d, required %0d", x, cap[2][x], 3 * (x + 1));
            end
        end
        checks++;
        if (eof_cnt - e0 != 1 || eof_ii != 12) begin
            errors++;
            $display("FAIL ones_eof: eof count %0d with ii=%0d, required 1 with ii=12", eof_cnt - e0, eof_ii);
        end
    endtask

    task automatic test_ramp();
        bit ok;
        int row0[4];
        row0 = '{0, 1, 3, 6};
        clear_cap();
        send_frame(1, 1'b0);
        drain(ok);
        checks++;
        if (!ok || last_ii != 66) begin
            errors++;
            $display("FAIL ramp_final: got ii=%0d drained=%0d, required 66 drained=1", last_ii, ok);
        end
        for (int x = 0; x < W; x++) begin
            checks++;
            if (cap[0][x] != row0[x]) begin
                errors++;
                $display("FAIL ramp_row0: x=%0d got %0d, required %0d", x, cap[0][x], row0[x]);
            end
        end
        checks++;
        if (cap[1][0] != 4) begin
            errors++;
            $display("FAIL ramp_ii01: got %0d, required 4", cap[1][0]);
        end
        save = cap;
        clear_cap();
        send_frame(1, 1'b1);
        drain(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL ramp_gap_drain: %0d outputs missing, required 0", q.size()); end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                checks++;
                if (cap[y][x] != save[y][x]) begin
                    errors++;
                    $display("FAIL ramp_gaps: (%0d,%0d) got %0d, required %0d", x, y, cap[y][x], save[y][x]);
                end
            end
        end
    endtask

    task automatic test_no_sof();
        int o0;
        bit ok;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        o0 = out_cnt;
        for (int i = 0; i < 5; i++) drive(i + 1, 1'b0);
        idle(4);
        checks++;
        if (out_cnt != o0) begin
            errors++;
            $display("FAIL no_sof_drop: got %0d outputs, required 0", out_cnt - o0);
        end
        clear_cap();
        send_frame(0, 1'b0);
        drain(ok);
        for (int x = 0; x < W; x++) begin
            checks++;
            if (!ok || cap[2][x] != 3 * (x + 1)) begin
                errors++;
                $display("FAIL no_sof_row2: x=%0d got %0d, required %0d", x, cap[2][x], 3 * (x + 1));
            end
        end
    endtask

    task automatic test_mid_sof();
        int er0;
        bit ok;
        er0 = err_cnt;
        clear_cap();
        for (int i = 0; i < 6; i++) drive(1, i == 0);
        send_frame(0, 1'b0);
        drain(ok);
        checks++;
        if (!ok || err_cnt - er0 != 1) begin
            errors++;
            $display("FAIL mid_sof_count: got %0d error pulses, required 1", err_cnt - er0);
        end
        checks++;
        if (err_ii != 1 || err_x != 0 || err_y != 0) begin
            errors++;
            $display("FAIL mid_sof_pos: got ii=%0d at (%0d,%0d), required ii=1 at (0,0)", err_ii, err_x, err_y);
        end
        for (int x = 0; x < W; x++) begin
            checks++;
            if (cap[2][x] != 3 * (x + 1)) begin
                errors++;
                $display("FAIL mid_sof_row2: x=%0d got %0d, required %0d", x, cap[2][x], 3 * (x + 1));
            end
        end
    endtask

    task automatic test_overflow();
        bit ok;
        send_frame(2, 1'b0);
        drain(ok);
        checks++;
        if (!ok || last_ii8 != 244) begin
            errors++;
            $display("FAIL overflow_sum8: got %0d, required 244", last_ii8);
        end
        checks++;
        if (last_ii != 3060) begin
            errors++;
            $display("FAIL overflow_wide: got %0d, required 3060", last_ii);
        end
    endtask

    task automatic test_reset_mid();
        int o0;
        bit ok;
        for (int i = 0; i < 6; i++) drive(1, i == 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        vld   = 1'b0;
        sof   = 1'b0;
        model_reset();
        o0 = out_cnt;
        @(negedge clk);
        checks++;
        if ({ii, ii_vld, ii_x, ii_y, ii_eof, ferr} !== '0 || {ii8, ii_vld8} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: ii=%0d vld=%0d x=%0d y=%0d ii8=%0d, required all 0",
                     ii, ii_vld, ii_x, ii_y, ii8);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(3);
        checks++;
        if (out_cnt != o0) begin
            errors++;
            $display("FAIL reset_mid_inflight: got %0d outputs, required 0", out_cnt - o0);
        end
        clear_cap();
        send_frame(0, 1'b0);
        drain(ok);
        for (int x = 0; x < W; x++) begin
            checks++;
            if (!ok || cap[2][x] != 3 * (x + 1)) begin
                errors++;
                $display("FAIL reset_mid_row2: x=%0d got %0d, required %0d", x, cap[2][x], 3 * (x + 1));
            end
        end
    endtask

    task automatic test_back_to_back();
        int e0;
        bit ok;
        e0 = eof_cnt;
        send_frame(1, 1'b0);
        send_frame(0, 1'b0);
        drain(ok);
        checks++;
        if (!ok || eof_cnt - e0 != 2 || eof_ii != 12) begin
            errors++;
            $display("FAIL b2b_eof: got %0d frames last ii=%0d, required 2 frames last ii=12", eof_cnt - e0, eof_ii);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_ramp();
        test_no_sof();
        test_mid_sof();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        idle(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
